// File: rtl/adc_stream_packetizer.sv
// Packs 16-bit ADC samples into 512-bit Avalon-ST beats and frames them into
// fixed-length packets, sequenced by arm / trigger-edge / packet-count / abort.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for cfg_arm; counters hold last acquisition's values
// S_ARMED | waiting for a rising edge on trig_in
// S_RUN   | capturing samples; abort_q set means a flush beat is pending
// S_DRAIN | waiting for the output register to empty, then pulse done
module adc_stream_packetizer #(
  parameter int SAMPLE_W = 16,
  parameter int DATA_W   = 512,
  parameter int EMPTY_W  = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_arm,
  input  logic                cfg_abort,
  input  logic [15:0]         cfg_beats,
  input  logic [15:0]         cfg_packets,
  input  logic                trig_in,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_data,
  output logic [DATA_W-1:0]   st_data,
  output logic                st_valid,
  input  logic                st_ready,
  output logic                st_sop,
  output logic                st_eop,
  output logic [EMPTY_W-1:0]  st_empty,
  output logic                busy,
  output logic                armed,
  output logic                done,
  output logic [15:0]         pkt_cnt,
  output logic [15:0]         ovf_cnt
);

  localparam int SPB              = DATA_W / SAMPLE_W;
  localparam int K_W              = $clog2(SPB + 1);
  localparam int BYTES_PER_SAMPLE = SAMPLE_W / 8;
  localparam logic [K_W-1:0] K_FULL = K_W'(SPB);
  localparam logic [K_W-1:0] K_LAST = K_W'(SPB - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic                 trig_q, trig_d;
  logic [DATA_W-1:0]    asm_q, asm_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [15:0]          b_q, b_d;
  logic [15:0]          pkt_ld_q, pkt_ld_d;
  logic                 abort_q, abort_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic [EMPTY_W-1:0]   empty_q, empty_d;
  logic [15:0]          pkt_cnt_q, pkt_cnt_d;
  logic [15:0]          ovf_cnt_q, ovf_cnt_d;
  logic                 done_q, done_d;

  logic [15:0]          beats_eff;
  logic                 out_free;
  logic                 last_in_pkt;
  logic                 final_pkt;
  logic                 load;
  logic [DATA_W-1:0]    load_beat;
  logic                 load_eop;
  logic [EMPTY_W-1:0]   load_empty;
  logic [DATA_W-1:0]    asm_ins;
  logic [DATA_W-1:0]    asm_first;
  logic [K_W-1:0]       k_eff;
  int                   k_int;

  always_comb begin
    beats_eff   = (cfg_beats == 16'd0) ? 16'd1 : cfg_beats;
    out_free    = !valid_q || st_ready;
    last_in_pkt = (b_q == beats_eff - 16'd1);
    final_pkt   = (cfg_packets != 16'd0) && (pkt_ld_q + 16'd1 == cfg_packets);
    k_int       = (k_q == K_FULL) ? 0 : int'(k_q);
    k_eff       = (k_q == '0) ? K_W'(1) : k_q;

    asm_ins = asm_q;
    asm_ins[k_int*SAMPLE_W +: SAMPLE_W] = adc_data;
    asm_first = '0;
    asm_first[SAMPLE_W-1:0] = adc_data;

    state_d   = state_q;
    trig_d    = trig_in;
    asm_d     = asm_q;
    k_d       = k_q;
    b_d       = b_q;
    pkt_ld_d  = pkt_ld_q;
    abort_d   = abort_q;
    data_d    = data_q;
    valid_d   = valid_q && !st_ready;
    sop_d     = sop_q;
    eop_d     = eop_q;
    empty_d   = empty_q;
    pkt_cnt_d = (valid_q && st_ready && eop_q) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    done_d    = 1'b0;
    load       = 1'b0;
    load_beat  = asm_q;
    load_eop   = last_in_pkt;
    load_empty = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_arm) begin
          state_d   = S_ARMED;
          pkt_cnt_d = '0;
          ovf_cnt_d = '0;
          asm_d     = '0;
          k_d       = '0;
          b_d       = '0;
          pkt_ld_d  = '0;
          abort_d   = 1'b0;
        end
      end
      S_ARMED: begin
        if (cfg_abort)              state_d = S_IDLE;
        else if (trig_in && !trig_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (!abort_q) begin
          if (adc_valid) begin
            if (k_q == K_LAST && out_free) begin
              // 32nd sample goes straight to the output register: 1-cycle latency
              load      = 1'b1;
              load_beat = asm_ins;
              asm_d     = '0;
              k_d       = '0;
            end else if (k_q == K_FULL) begin
              if (out_free) begin
                load  = 1'b1;
                asm_d = asm_first;
                k_d   = K_W'(1);
              end else if (ovf_cnt_q != 16'hFFFF) begin
                ovf_cnt_d = ovf_cnt_q + 16'd1;
              end
            end else begin
              asm_d = asm_ins;
              k_d   = k_q + K_W'(1);
            end
          end else if (k_q == K_FULL && out_free) begin
            load  = 1'b1;
            asm_d = '0;
            k_d   = '0;
          end
          if (cfg_abort && !(load && last_in_pkt && final_pkt)) abort_d = 1'b1;
        end else begin
          if (k_q == '0 && b_q == 16'd0) begin
            state_d = S_DRAIN;
          end else if (out_free) begin
            load       = 1'b1;
            load_eop   = 1'b1;
            load_empty = EMPTY_W'((SPB - int'(k_eff)) * BYTES_PER_SAMPLE);
            asm_d      = '0;
            k_d        = '0;
            state_d    = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!valid_q || st_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      data_d  = load_beat;
      valid_d = 1'b1;
      sop_d   = (b_q == 16'd0);
      eop_d   = load_eop;
      empty_d = load_empty;
      if (load_eop) begin
        b_d      = '0;
        pkt_ld_d = pkt_ld_q + 16'd1;
        if (final_pkt) state_d = S_DRAIN;
      end else begin
        b_d = b_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      trig_q    <= 1'b0;
      asm_q     <= '0;
      k_q       <= '0;
      b_q       <= '0;
      pkt_ld_q  <= '0;
      abort_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= '0;
      pkt_cnt_q <= '0;
      ovf_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trig_d;
      asm_q     <= asm_d;
      k_q       <= k_d;
      b_q       <= b_d;
      pkt_ld_q  <= pkt_ld_d;
      abort_q   <= abort_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      empty_q   <= empty_d;
      pkt_cnt_q <= pkt_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      done_q    <= done_d;
    end
  end

  assign st_data  = data_q;
  assign st_valid = valid_q;
  assign st_sop   = sop_q;
  assign st_eop   = eop_q;
  assign st_empty = empty_q;
  assign busy     = (state_q != S_IDLE);
  assign armed    = (state_q == S_ARMED);
  assign done     = done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign ovf_cnt  = ovf_cnt_q;

endmodule

// File: tb/tb_adc_stream_packetizer.sv
// Bench for adc_stream_packetizer: a table of acquisition cases plus hand-built
// corner sequences; a packing model queues expected beats, a monitor pops them.
module tb_adc_stream_packetizer;

  localparam int SAMPLE_W = 16;
  localparam int DATA_W   = 512;
  localparam int EMPTY_W  = 6;
  localparam int SPB      = DATA_W / SAMPLE_W;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                cfg_arm, cfg_abort;
  logic [15:0]         cfg_beats, cfg_packets;
  logic                trig_in, adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic [DATA_W-1:0]   st_data;
  logic                st_valid, st_ready, st_sop, st_eop;
  logic [EMPTY_W-1:0]  st_empty;
  logic                busy, armed, done;
  logic [15:0]         pkt_cnt, ovf_cnt;

  always #5 clk = ~clk;

  adc_stream_packetizer #(.SAMPLE_W(SAMPLE_W), .DATA_W(DATA_W), .EMPTY_W(EMPTY_W)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_beats(cfg_beats), .cfg_packets(cfg_packets), .trig_in(trig_in),
    .adc_valid(adc_valid), .adc_data(adc_data), .st_data(st_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_sop(st_sop), .st_eop(st_eop),
    .st_empty(st_empty), .busy(busy), .armed(armed), .done(done),
    .pkt_cnt(pkt_cnt), .ovf_cnt(ovf_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } beat_t;

  typedef struct {
    int beats;
    int pkts;
    int nsamp;
    bit abort;
    int exp_pkt;
  } case_t;

  beat_t             exp_q[$];
  int                vec_cnt = 0;
  int                mis_cnt = 0;
  int                m_k, m_b, m_beats;
  logic [DATA_W-1:0] m_asm;
  case_t             cases[7];

  task automatic chk(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_init(input int beats);
    m_beats = (beats == 0) ? 1 : beats;
    m_k     = 0;
    m_b     = 0;
    m_asm   = '0;
  endtask

  task automatic push_beat(input logic [DATA_W-1:0] d, input logic eop, input logic [EMPTY_W-1:0] empty);
    beat_t bt;
    bt.data  = d;
    bt.sop   = (m_b == 0);
    bt.eop   = eop;
    bt.empty = empty;
    exp_q.push_back(bt);
    m_b = eop ? 0 : m_b + 1;
  endtask

  task automatic model_sample(input logic [SAMPLE_W-1:0] s);
    m_asm[m_k*SAMPLE_W +: SAMPLE_W] = s;
    m_k++;
    if (m_k == SPB) begin
      push_beat(m_asm, (m_b == m_beats - 1), '0);
      m_asm = '0;
      m_k   = 0;
    end
  endtask

  task automatic model_abort();
    if (m_k > 0)       push_beat(m_asm, 1'b1, EMPTY_W'(2 * (SPB - m_k)));
    else if (m_b > 0)  push_beat('0, 1'b1, EMPTY_W'(62));
  endtask

  // Scoreboard: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && st_valid && st_ready) begin
      if (exp_q.size() == 0) begin
        vec_cnt++;
        mis_cnt++;
        $display("FAIL unexpected_beat: got beat sop=%0b eop=%0b empty=%0d, required no beat",
                 st_sop, st_eop, st_empty);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data",  st_data, e.data);
        chk("beat_sop",   DATA_W'(st_sop), DATA_W'(e.sop));
        chk("beat_eop",   DATA_W'(st_eop), DATA_W'(e.eop));
        chk("beat_empty", DATA_W'(st_empty), DATA_W'(e.empty));
      end
    end
  end

  task automatic arm_trigger();
    trig_in = 1'b0;
    cfg_arm = 1'b1;
    step();
    cfg_arm = 1'b0;
    trig_in = 1'b1;
    step();
  endtask

  task automatic drive_sample(input logic [SAMPLE_W-1:0] s, input bit push);
    adc_valid = 1'b1;
    adc_data  = s;
    if (push) model_sample(s);
    step();
    adc_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 500 && !done; i++) step();
    chk({name, "_done"}, DATA_W'(done), DATA_W'(1));
    step();
    chk({name, "_done_pulse"}, DATA_W'(done), DATA_W'(0));
    chk({name, "_idle"}, DATA_W'(busy), DATA_W'(0));
    chk({name, "_beats_left"}, DATA_W'(exp_q.size()), DATA_W'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] beat0;

    cases[0] = '{beats: 2, pkts: 1, nsamp: 64, abort: 1'b0, exp_pkt: 1};
    cases[1] = '{beats: 1, pkts: 3, nsamp: 96, abort: 1'b0, exp_pkt: 3};
    cases[2] = '{beats: 1, pkts: 0, nsamp: 5,  abort: 1'b1, exp_pkt: 1};
    cases[3] = '{beats: 4, pkts: 0, nsamp: 32, abort: 1'b1, exp_pkt: 1};
    cases[4] = '{beats: 3, pkts: 0, nsamp: 0,  abort: 1'b1, exp_pkt: 0};
    cases[5] = '{beats: 0, pkts: 2, nsamp: 64, abort: 1'b0, exp_pkt: 2};
    cases[6] = '{beats: 2, pkts: 0, nsamp: 40, abort: 1'b1, exp_pkt: 1};

    reset_n = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_beats = 16'd1;
    cfg_packets = 16'd1; trig_in = 1'b0; adc_valid = 1'b0; adc_data = '0;
    st_ready = 1'b1;
    repeat (3) step();
    chk("rst_valid", DATA_W'(st_valid), DATA_W'(0));
    chk("rst_busy",  DATA_W'(busy),     DATA_W'(0));
    chk("rst_armed", DATA_W'(armed),    DATA_W'(0));
    chk("rst_pkt",   DATA_W'(pkt_cnt),  DATA_W'(0));
    chk("rst_ovf",   DATA_W'(ovf_cnt),  DATA_W'(0));
    chk("rst_data",  st_data,           '0);
    reset_n = 1'b1;
    step();

    for (int c = 0; c < 7; c++) begin
      cfg_beats   = 16'(cases[c].beats);
      cfg_packets = 16'(cases[c].pkts);
      st_ready    = 1'b1;
      model_init(cases[c].beats);
      arm_trigger();
      for (int i = 0; i < cases[c].nsamp; i++)
        drive_sample((c == 0) ? 16'(i) : 16'(c * 256 + i), 1'b1);
      if (cases[c].abort) begin
        cfg_abort = 1'b1;
        model_abort();
        step();
        cfg_abort = 1'b0;
      end
      wait_done($sformatf("case%0d", c));
      chk($sformatf("case%0d_pkt_cnt", c), DATA_W'(pkt_cnt), DATA_W'(cases[c].exp_pkt));
      chk($sformatf("case%0d_ovf_cnt", c), DATA_W'(ovf_cnt), DATA_W'(0));
    end

    // Trigger already high at arm time: needs a fresh low->high edge.
    cfg_beats = 16'd1; cfg_packets = 16'd1; st_ready = 1'b1;
    model_init(1);
    trig_in = 1'b1;
    cfg_arm = 1'b1;
    step();
    cfg_arm   = 1'b0;
    adc_valid = 1'b1;
    adc_data  = 16'hDEAD;
    repeat (5) step();
    chk("trig_high_armed", DATA_W'(armed),    DATA_W'(1));
    chk("trig_high_valid", DATA_W'(st_valid), DATA_W'(0));
    trig_in = 1'b0;
    step();
    trig_in = 1'b1;
    step();
    chk("trig_edge_armed", DATA_W'(armed), DATA_W'(0));
    for (int i = 0; i < SPB; i++) drive_sample(16'(16'h4000 + i), 1'b1);
    chk("latency_valid", DATA_W'(st_valid), DATA_W'(1));
    wait_done("trig");
    chk("trig_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(1));

    // Backpressure: 70 samples against a stalled sink, 6 must be dropped.
    cfg_beats = 16'd1; cfg_packets = 16'd2; st_ready = 1'b0;
    model_init(1);
    beat0 = '0;
    for (int j = 0; j < SPB; j++) beat0[j*SAMPLE_W +: SAMPLE_W] = 16'(j);
    arm_trigger();
    for (int i = 0; i < 70; i++) begin
      drive_sample(16'(i), (i < 64));
      if (i == 40) chk("stall_data_early", st_data, beat0);
    end
    chk("stall_valid",     DATA_W'(st_valid), DATA_W'(1));
    chk("stall_data_late", st_data, beat0);
    chk("stall_sop",       DATA_W'(st_sop),   DATA_W'(1));
    chk("stall_ovf_cnt",   DATA_W'(ovf_cnt),  DATA_W'(6));
    st_ready = 1'b1;
    wait_done("stall");
    chk("stall_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(2));
    chk("stall_ovf_hold", DATA_W'(ovf_cnt), DATA_W'(6));

    // Abort in the same cycle the final beat completes: no flush beat.
    cfg_beats = 16'd2; cfg_packets = 16'd1; st_ready = 1'b1;
    model_init(2);
    arm_trigger();
    for (int i = 0; i < 2 * SPB; i++) begin
      cfg_abort = (i == 2 * SPB - 1);
      drive_sample(16'(16'h7000 + i), 1'b1);
    end
    cfg_abort = 1'b0;
    wait_done("abort_final");
    chk("abort_final_pkt_cnt", DATA_W'(pkt_cnt), DATA_W'(1));

    // Reset during RUN with a stalled beat and a nonzero drop count.
    cfg_beats = 16'd1; cfg_packets = 16'd0; st_ready = 1'b0;
    model_init(1);
    arm_trigger();
    for (int i = 0; i < 70; i++) drive_sample(16'(i), 1'b0);
    chk("pre_rst_ovf", DATA_W'(ovf_cnt), DATA_W'(6));
    reset_n = 1'b0;
    step();
    chk("mid_rst_valid", DATA_W'(st_valid), DATA_W'(0));
    chk("mid_rst_busy",  DATA_W'(busy),     DATA_W'(0));
    chk("mid_rst_ovf",   DATA_W'(ovf_cnt),  DATA_W'(0));
    chk("mid_rst_pkt",   DATA_W'(pkt_cnt),  DATA_W'(0));
    reset_n = 1'b1;
    exp_q.delete();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
